serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder that feeds one operand bit pair per clock into a single `fulladder` cell and registers its `sum`/`c_out` outputs back into a result shift register and carry flip-flop. It sits directly around the `fulladder` cell: it sequences that cell's inputs and consumes its outputs. The block trades WIDTH cycles of latency for one full-adder cell of area and serves as the sequential counterpart to the combinational adder datapath.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a_in  in  WIDTH  operand A; captured on the accepted start.
- b_in  in  WIDTH  operand B; captured on the accepted start.
- cin  in  1  carry-in; captured on the accepted start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the result is valid.
- sum_out  out  WIDTH  registered sum; holds until the next done.
- cout  out  1  registered final carry; holds until the next done.
- ovf  out  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- The clock and reset are fixed: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset forces state to IDLE and clears every register and output to 0: busy, done, sum_out, cout, ovf, shift registers, carry flip-flop and counter.
- States and transitions:
  - IDLE:
    - On start=1, capture a_in, b_in and cin.
    - Clear the counter and go to RUN.
    - With start=0, stay in IDLE.
  - RUN, each cycle:
    - Drive the fulladder with a=A[0], b=B[0] and cin=carry flip-flop.
    - Shift A and B right by one.
    - Shift the fulladder `sum` into the MSB of S, shifting S right.
    - Load the carry flip-flop from `c_out`.
    - Increment the counter.
    - After the RUN cycle in which the counter equals WIDTH-1, go to DONE.
  - DONE:
    - Copy S to sum_out and the carry flip-flop to cout.
    - Assert done for exactly one cycle.
    - Return to IDLE.
- start is ignored in RUN and DONE; it is not queued.
- Arithmetic: {cout, sum_out} = a_in + b_in + cin, evaluated modulo 2^(WIDTH+1).
- If reset asserts mid-operation, the operation aborts immediately, no done is issued and the outputs read 0.

## Timing
- Start accepted at edge T0; RUN occupies edges T1..TWIDTH; done is high during the cycle after edge TWIDTH+1.
- Latency from the start edge to done is WIDTH+1 cycles; WIDTH=8 gives 9.
- busy rises at the start edge and falls on the edge on which done falls.
- Back-to-back operation: the earliest next accepted start is the edge after done falls, giving a throughput of one result per WIDTH+2 cycles.
- sum_out and cout change only on the edge that raises done, or on reset.

## Configuration
- The macro is SERIAL_ADDER_OVF_EN.
- When defined:
  - The `ovf` port exists.
  - The block registers the carry into the MSB, i.e. the carry flip-flop value at the final RUN cycle's input.
  - ovf = carry-into-MSB XOR final carry, updated together with sum_out.
  - ovf resets to 0.
- When undefined, the `ovf` port and its logic are absent; all other behaviour is identical.

## Structure
- The shared package `serial_adder_pkg` holds:
  - the state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a counter-width function or constant, $clog2(WIDTH).
- Sub-module: exactly one instance of the existing `fulladder` (ports a, b, cin, sum, c_out); no other arithmetic in the block.

## Test plan
- WIDTH=8, A=0x00, B=0x00, cin=0, start at T0 → done exactly at cycle 9, sum_out=0x00, cout=0, busy high for cycles 1..9.
- A=0xFF, B=0x01, cin=0 → sum_out=0x00, cout=1; then A=0x5A, B=0xA5, cin=1 → sum_out=0x00, cout=1; then A=0x12, B=0x34, cin=0 → sum_out=0x46, cout=0, run back-to-back at the earliest legal starts.
- start held high continuously with changing a_in/b_in during RUN → only the operands from the first accepted edge are used; exactly one done per WIDTH+2 cycles.
- rst pulsed at cycle 4 of an operation → all outputs 0 asynchronously, no done pulse; the next start completes normally (0x03+0x04 → 0x07).
- With SERIAL_ADDER_OVF_EN:
  - 0x7F+0x01, cin=0 → sum_out=0x80, cout=0, ovf=1.
  - 0x80+0x80 → sum_out=0x00, cout=1, ovf=1.
  - 0xFF+0x01 → ovf=0.
- Exhaustive WIDTH=2 sweep of all a, b, cin combinations (32 cases) → {cout, sum_out} matches a+b+cin for every case.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-index counter width; a 1-bit counter still covers the minimum WIDTH of 2.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell shared by the adder datapaths.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ cin;
  assign c_out = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per cycle through a single fulladder, done after WIDTH+1 cycles.
// Optional signed-overflow output under SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fa_sum;
  logic             fa_cout;

  assign last = (state == RUN) && (cnt == CW'(WIDTH - 1));

  fulladder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
        end
        DONE: begin
          sum_out <= s_sr;
          cout    <= carry;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Carry entering the MSB is the carry register as it stood during the last RUN cycle.
  logic cmsb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmsb <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (last) cmsb <= carry;
      if (state == DONE) ovf <= cmsb ^ carry;
    end
  end
`endif

  // Kept high through the done cycle so busy falls together with done.
  assign busy = (state != IDLE) || done;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed vectors plus a WIDTH=2 exhaustive sweep.
module tb_serial_adder;

  typedef struct {
    logic [8:0] res;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  exp_t       q8[$];
  exp_t       q2[$];

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf2;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_in(a2), .b_in(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum_out(sum2), .cout(cout2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("res8", {23'd0, cout8, sum8}, {23'd0, e.res});
        chk("done8_cycle", cyc, e.cyc);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        chk("done2_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("res2", {29'd0, cout2, sum2}, {23'd0, e.res});
        chk("done2_cycle", cyc, e.cyc);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf2", {31'd0, ovf2}, {31'd0, e.ovf});
`endif
      end
    end
  end

  // Issues one WIDTH=8 operation and returns just in time for the earliest next start.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] res, input logic ov);
    exp_t e;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    e.res = res; e.ovf = ov; e.cyc = cyc + 1 + 9;
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    repeat (9) @(posedge clk);
    #1;
  endtask

  task automatic issue2(input int a, input int b, input int c);
    exp_t e;
    logic [2:0] s;
    s = 3'(a + b + c);
    a2 = 2'(a); b2 = 2'(b); cin2 = 1'(c); start2 = 1'b1;
    e.res = {6'd0, s};
    e.ovf = (a2[1] == b2[1]) && (s[1] != a2[1]);
    e.cyc = cyc + 1 + 3;
    q2.push_back(e);
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_res", {23'd0, cout8, sum8}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", {31'd0, ovf8}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Zero add with busy traced every cycle from the start edge through done.
    chk("idle_busy", {31'd0, busy8}, 32'd0);
    start8 = 1'b1;
    e.res = 9'h000; e.ovf = 1'b0; e.cyc = cyc + 1 + 9;
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("busy_c0", {31'd0, busy8}, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("busy_c%0d", i), {31'd0, busy8}, (i <= 9) ? 32'd1 : 32'd0);
    end

    // Back-to-back at the earliest legal starts.
    issue8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
    issue8(8'h5A, 8'hA5, 1'b1, 9'h100, 1'b0);
    issue8(8'h12, 8'h34, 1'b0, 9'h046, 1'b0);

    // start held high: operands only taken at T0 and T10.
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    e.res = 9'h010; e.ovf = 1'b0; e.cyc = cyc + 1 + 9;
    q8.push_back(e);
    e.res = 9'h180; e.ovf = 1'b0; e.cyc = cyc + 1 + 19;
    q8.push_back(e);
    for (int k = 0; k < 19; k++) begin
      @(posedge clk); #1;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      if (k == 9) begin
        a8 = 8'hC0; b8 = 8'hC0; cin8 = 1'b0;
      end
    end
    start8 = 1'b0;
    @(posedge clk); #1;

    // Reset during RUN clears outputs immediately and suppresses done.
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_res", {23'd0, cout8, sum8}, 32'd0);
    chk("arst_busy", {31'd0, busy8}, 32'd0);
    chk("arst_done", {31'd0, done8}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("arst_ovf", {31'd0, ovf8}, 32'd0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    issue8(8'h03, 8'h04, 1'b0, 9'h007, 1'b0);

    // Signed overflow vectors.
    issue8(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
    issue8(8'h80, 8'h80, 1'b0, 9'h100, 1'b1);
    issue8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          issue2(a, b, c);

    repeat (5) @(posedge clk);
    #1;
    chk("q8_drained", q8.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
